// File: rtl/ls_scheduler_if.sv
// Memory-side request/response bus of the load/store scheduler.
// master = scheduler side, slave = memory side.
interface ls_scheduler_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [1:0]            mem_size_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic                  mem_gnt_i;
    logic                  mem_rvalid_i;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_size_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/ls_scheduler.sv
// Dual-issue load/store queue feeding a single-outstanding memory port.
// Optional LS_PERF_CNT_EN adds saturating granted-load/store counters.
module ls_scheduler #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ls_valid1_i,
    input  logic [2:0]            ls_type1_i,
    input  logic [ADDR_WIDTH-1:0] addr1_i,
    input  logic [DATA_WIDTH-1:0] wdata1_i,
    input  logic                  ls_valid2_i,
    input  logic [2:0]            ls_type2_i,
    input  logic [ADDR_WIDTH-1:0] addr2_i,
    input  logic [DATA_WIDTH-1:0] wdata2_i,
    output logic                  ls_ready_o,
    ls_scheduler_if.master        mem_bus,
    output logic                  ld_valid_o,
    output logic [DATA_WIDTH-1:0] ld_data_o,
    output logic                  busy_o
`ifdef LS_PERF_CNT_EN
    ,
    output logic [15:0]           ld_cnt_o,
    output logic [15:0]           st_cnt_o
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RD} state_t;

    function automatic logic [1:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 2'b10;
            2'b01:   return 2'b01;
            2'b10:   return 2'b00;
            default: return 2'b10;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] st_align(input logic [1:0] sz,
                                                       input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        case (sz)
            2'b01:   r[15:0] = d[15:0];
            2'b10:   r[7:0]  = d[7:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] ld_extend(input logic [1:0] sz,
                                                        input logic [DATA_WIDTH-1:0] d);
        logic signed [15:0]           h;
        logic signed [7:0]            b;
        logic signed [DATA_WIDTH-1:0] r;
        h = signed'(d[15:0]);
        b = signed'(d[7:0]);
        case (sz)
            2'b01:   r = h;
            2'b10:   r = b;
            default: r = signed'(d);
        endcase
        return r;
    endfunction

    logic [2:0]            q_type  [DEPTH];
    logic [ADDR_WIDTH-1:0] q_addr  [DEPTH];
    logic [DATA_WIDTH-1:0] q_wdata [DEPTH];

    logic [PW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr2;
    logic [CW-1:0] count_q, count_nxt;
    logic          push1, push2, pop;
    state_t        state_q, state_nxt;

    logic [2:0]            head_type;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    logic [1:0]            ld_type_p0;
    logic                  ld_vld_p1;
    logic [DATA_WIDTH-1:0] ld_data_p1;

    // Ready depends only on registered occupancy: room for a full pair.
    assign ls_ready_o = (count_q <= CW'(DEPTH - 2));

    assign push1   = ls_ready_o && ls_valid1_i && (ls_type1_i[1:0] != 2'b11);
    assign push2   = ls_ready_o && ls_valid2_i && (ls_type2_i[1:0] != 2'b11);
    assign wr_ptr2 = wr_ptr_q + PW'(push1);

    assign head_type  = q_type[rd_ptr_q];
    assign head_addr  = q_addr[rd_ptr_q];
    assign head_wdata = q_wdata[rd_ptr_q];

    assign pop       = (state_q == S_REQ) && mem_bus.mem_gnt_i;
    assign count_nxt = count_q + CW'(push1) + CW'(push2) - CW'(pop);
    assign busy_o    = (count_q != '0) || (state_q != S_IDLE);

    // Queue control
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push1) + PW'(push2);
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            count_q  <= count_nxt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push1) begin
            q_type[wr_ptr_q]  <= ls_type1_i;
            q_addr[wr_ptr_q]  <= addr1_i;
            q_wdata[wr_ptr_q] <= wdata1_i;
        end
        if (push2) begin
            q_type[wr_ptr2]  <= ls_type2_i;
            q_addr[wr_ptr2]  <= addr2_i;
            q_wdata[wr_ptr2] <= wdata2_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:    if (count_q != '0) state_nxt = S_REQ;
            S_REQ: begin
                if (mem_bus.mem_gnt_i) begin
                    if (head_type[2]) state_nxt = (count_nxt != '0) ? S_REQ : S_IDLE;
                    else              state_nxt = S_WAIT_RD;
                end
            end
            S_WAIT_RD: if (mem_bus.mem_rvalid_i) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Head entry is presented only in REQ, so the bus reads zero otherwise.
    always_comb begin
        mem_bus.mem_req_o   = 1'b0;
        mem_bus.mem_we_o    = 1'b0;
        mem_bus.mem_size_o  = 2'b00;
        mem_bus.mem_addr_o  = '0;
        mem_bus.mem_wdata_o = '0;
        if (state_q == S_REQ) begin
            mem_bus.mem_req_o  = 1'b1;
            mem_bus.mem_we_o   = head_type[2];
            mem_bus.mem_size_o = size_of(head_type[1:0]);
            mem_bus.mem_addr_o = head_addr;
            if (head_type[2]) mem_bus.mem_wdata_o = st_align(head_type[1:0], head_wdata);
        end
    end

    // Stage p0: remember load width at grant; stage p1: extended load result
    always_ff @(posedge clk_i) begin
        if (pop && !head_type[2]) ld_type_p0 <= head_type[1:0];
        if ((state_q == S_WAIT_RD) && mem_bus.mem_rvalid_i)
            ld_data_p1 <= ld_extend(ld_type_p0, mem_bus.mem_rdata_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ld_vld_p1 <= 1'b0;
        else       ld_vld_p1 <= (state_q == S_WAIT_RD) && mem_bus.mem_rvalid_i;
    end

    assign ld_valid_o = ld_vld_p1;
    assign ld_data_o  = ld_vld_p1 ? ld_data_p1 : '0;

`ifdef LS_PERF_CNT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    logic [15:0] ld_cnt_q, st_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ld_cnt_q <= '0;
            st_cnt_q <= '0;
        end else if (pop) begin
            if (head_type[2]) st_cnt_q <= sat_inc(st_cnt_q);
            else              ld_cnt_q <= sat_inc(ld_cnt_q);
        end
    end

    assign ld_cnt_o = ld_cnt_q;
    assign st_cnt_o = st_cnt_q;
`endif

endmodule

// File: tb/tb_ls_scheduler.sv
// Directed bench for ls_scheduler: per-op vector table plus multi-cycle sequences.
module tb_ls_scheduler;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v1 = 1'b0, v2 = 1'b0;
    logic [2:0]    t1 = 3'b000, t2 = 3'b000;
    logic [AW-1:0] a1 = '0, a2 = '0;
    logic [DW-1:0] d1 = '0, d2 = '0;
    logic          ready, ld_valid, busy;
    logic [DW-1:0] ld_data;
`ifdef LS_PERF_CNT_EN
    logic [15:0]   ld_cnt, st_cnt;
`endif

    always #5 clk = ~clk;

    ls_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    ls_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .ls_valid1_i(v1), .ls_type1_i(t1), .addr1_i(a1), .wdata1_i(d1),
        .ls_valid2_i(v2), .ls_type2_i(t2), .addr2_i(a2), .wdata2_i(d2),
        .ls_ready_o(ready), .mem_bus(mem.master),
        .ld_valid_o(ld_valid), .ld_data_o(ld_data), .busy_o(busy)
`ifdef LS_PERF_CNT_EN
        , .ld_cnt_o(ld_cnt), .st_cnt_o(st_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        string         name;
        logic [2:0]    typ;
        logic [31:0]   addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic          we;
        logic [1:0]    size;
        logic [31:0]   exp_wdata;
        logic [31:0]   exp_ld;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string name);
        int n;
        n = 0;
        while (mem.mem_req_o !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({name, "_req"}, 32'(mem.mem_req_o), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        v1 = 1'b1; t1 = v.typ; a1 = v.addr; d1 = v.wdata;
        tick();
        v1 = 1'b0;
        wait_req(v.name);
        check({v.name, "_we"},    32'(mem.mem_we_o),   32'(v.we));
        check({v.name, "_size"},  32'(mem.mem_size_o), 32'(v.size));
        check({v.name, "_addr"},  mem.mem_addr_o,      v.addr);
        check({v.name, "_wdata"}, mem.mem_wdata_o,     v.exp_wdata);
        mem.mem_gnt_i = 1'b1;
        tick();
        mem.mem_gnt_i = 1'b0;
        if (!v.we) begin
            check({v.name, "_busy_wait"}, 32'(busy), 32'd1);
            mem.mem_rvalid_i = 1'b1;
            mem.mem_rdata_i  = v.rdata;
            tick();
            mem.mem_rvalid_i = 1'b0;
            check({v.name, "_ldv"},  32'(ld_valid), 32'd1);
            check({v.name, "_ldd"},  ld_data,       v.exp_ld);
            tick();
            check({v.name, "_ldv_end"}, 32'(ld_valid), 32'd0);
        end else begin
            check({v.name, "_req_end"}, 32'(mem.mem_req_o), 32'd0);
            tick();
        end
    endtask

    initial begin
        mem.mem_gnt_i    = 1'b0;
        mem.mem_rvalid_i = 1'b0;
        mem.mem_rdata_i  = '0;

        vecs[0] = '{"lw",    3'b000, 32'h100, 32'h0,        32'h12345678, 1'b0, 2'b10, 32'h0,        32'h12345678};
        vecs[1] = '{"sw",    3'b100, 32'h104, 32'hDEADBEEF, 32'h0,        1'b1, 2'b10, 32'hDEADBEEF, 32'h0};
        vecs[2] = '{"lb",    3'b010, 32'h21,  32'h0,        32'h00000080, 1'b0, 2'b00, 32'h0,        32'hFFFFFF80};
        vecs[3] = '{"lh",    3'b001, 32'h22,  32'h0,        32'h00007FFF, 1'b0, 2'b01, 32'h0,        32'h00007FFF};
        vecs[4] = '{"lh_neg",3'b001, 32'h24,  32'h0,        32'h12348001, 1'b0, 2'b01, 32'h0,        32'hFFFF8001};
        vecs[5] = '{"sb",    3'b110, 32'h3,   32'h123456AB, 32'h0,        1'b1, 2'b00, 32'h000000AB, 32'h0};
        vecs[6] = '{"sh",    3'b101, 32'h6,   32'hCAFEF00D, 32'h0,        1'b1, 2'b01, 32'h0000F00D, 32'h0};
        vecs[7] = '{"lb_pos",3'b010, 32'h27,  32'h0,        32'hFFFFFF7F, 1'b0, 2'b00, 32'h0,        32'h0000007F};

        // Reset state
        #2;
        tick();
        check("rst_ready", 32'(ready),           32'd1);
        check("rst_req",   32'(mem.mem_req_o),   32'd0);
        check("rst_we",    32'(mem.mem_we_o),    32'd0);
        check("rst_size",  32'(mem.mem_size_o),  32'd0);
        check("rst_addr",  mem.mem_addr_o,       32'd0);
        check("rst_wdata", mem.mem_wdata_o,      32'd0);
        check("rst_ldv",   32'(ld_valid),        32'd0);
        check("rst_ldd",   ld_data,              32'd0);
        check("rst_busy",  32'(busy),            32'd0);
        rst = 1'b0;
        tick();

        // Pair LW@0x100 + SW@0x104 with grant held high
        v1 = 1'b1; t1 = 3'b000; a1 = 32'h100; d1 = 32'h0;
        v2 = 1'b1; t2 = 3'b100; a2 = 32'h104; d2 = 32'hDEADBEEF;
        mem.mem_gnt_i = 1'b1;
        tick();
        v1 = 1'b0; v2 = 1'b0;
        tick();
        check("pair_lw_req",  32'(mem.mem_req_o), 32'd1);
        check("pair_lw_we",   32'(mem.mem_we_o),  32'd0);
        check("pair_lw_addr", mem.mem_addr_o,     32'h100);
        tick();
        check("pair_wait_req", 32'(mem.mem_req_o), 32'd0);
        mem.mem_rvalid_i = 1'b1; mem.mem_rdata_i = 32'h12345678;
        tick();
        mem.mem_rvalid_i = 1'b0;
        check("pair_ldv", 32'(ld_valid), 32'd1);
        check("pair_ldd", ld_data,       32'h12345678);
        tick();
        check("pair_sw_req",   32'(mem.mem_req_o),  32'd1);
        check("pair_sw_we",    32'(mem.mem_we_o),   32'd1);
        check("pair_sw_size",  32'(mem.mem_size_o), 32'd2);
        check("pair_sw_addr",  mem.mem_addr_o,      32'h104);
        check("pair_sw_wdata", mem.mem_wdata_o,     32'hDEADBEEF);
        tick();
        mem.mem_gnt_i = 1'b0;
        check("pair_idle_busy", 32'(busy), 32'd0);
        tick();

        // Table of single operations
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Fill the queue with four stores while grant is withheld
        v1 = 1'b1; t1 = 3'b100; a1 = 32'h10; d1 = 32'hA0;
        v2 = 1'b1; t2 = 3'b100; a2 = 32'h14; d2 = 32'hA1;
        tick();
        check("fill_ready_mid", 32'(ready), 32'd1);
        a1 = 32'h18; d1 = 32'hA2; a2 = 32'h1C; d2 = 32'hA3;
        tick();
        a1 = 32'h999; a2 = 32'h998;
        check("full_ready", 32'(ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("full_req",  32'(mem.mem_req_o), 32'd1);
            check("full_addr", mem.mem_addr_o,     32'h10);
            tick();
        end
        v1 = 1'b0; v2 = 1'b0;
        mem.mem_gnt_i = 1'b1;
        tick();
        mem.mem_gnt_i = 1'b0;
        check("one_free_ready", 32'(ready),     32'd0);
        check("one_free_addr",  mem.mem_addr_o, 32'h14);
        mem.mem_gnt_i = 1'b1;
        tick();
        check("two_free_ready", 32'(ready),     32'd1);
        check("drain_addr3",    mem.mem_addr_o, 32'h18);
        tick();
        check("drain_addr4",    mem.mem_addr_o, 32'h1C);
        check("drain_wdata4",   mem.mem_wdata_o, 32'hA3);
        tick();
        mem.mem_gnt_i = 1'b0;
        check("drain_busy", 32'(busy), 32'd0);
        tick();
        check("drain_noreq", 32'(mem.mem_req_o), 32'd0);

        // Reserved slot-1 type discarded, slot-2 SB issued alone
        v1 = 1'b1; t1 = 3'b111; a1 = 32'h777; d1 = 32'h11111111;
        v2 = 1'b1; t2 = 3'b110; a2 = 32'h3;   d2 = 32'hFFFFFF5A;
        tick();
        v1 = 1'b0; v2 = 1'b0;
        wait_req("disc");
        check("disc_addr",  mem.mem_addr_o,      32'h3);
        check("disc_size",  32'(mem.mem_size_o), 32'd0);
        check("disc_we",    32'(mem.mem_we_o),   32'd1);
        check("disc_wdata", mem.mem_wdata_o,     32'h5A);
        mem.mem_gnt_i = 1'b1;
        tick();
        mem.mem_gnt_i = 1'b0;
        check("disc_busy", 32'(busy), 32'd0);
        tick();
        check("disc_noreq", 32'(mem.mem_req_o), 32'd0);

        // Reset while waiting for load data
        v1 = 1'b1; t1 = 3'b000; a1 = 32'h200;
        tick();
        v1 = 1'b0;
        wait_req("rstwr");
        mem.mem_gnt_i = 1'b1;
        tick();
        mem.mem_gnt_i = 1'b0;
        check("rstwr_busy_pre", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rstwr_busy_async",  32'(busy),  32'd0);
        check("rstwr_ready_async", 32'(ready), 32'd1);
        tick();
        rst = 1'b0;
        mem.mem_rvalid_i = 1'b1; mem.mem_rdata_i = 32'hCAFECAFE;
        tick();
        mem.mem_rvalid_i = 1'b0;
        check("rstwr_ldv",  32'(ld_valid), 32'd0);
        check("rstwr_ldd",  ld_data,       32'd0);
        check("rstwr_busy", 32'(busy),     32'd0);
        tick();
        check("rstwr_ldv2", 32'(ld_valid), 32'd0);

`ifdef LS_PERF_CNT_EN
        do_reset();
        check("cnt_rst_ld", 32'(ld_cnt), 32'd0);
        check("cnt_rst_st", 32'(st_cnt), 32'd0);
        run_vec(vecs[0]);
        run_vec(vecs[1]);
        run_vec(vecs[2]);
        run_vec(vecs[3]);
        run_vec(vecs[5]);
        check("cnt_ld", 32'(ld_cnt), 32'd3);
        check("cnt_st", 32'(st_cnt), 32'd2);
`else
        do_reset();
        check("final_busy", 32'(busy), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
